// File: rtl/sar_avg_osr_core.sv
// SAR ADC digital core: N_BITS successive approximation with majority-vote
// repetition on the lowest N_AVG_LSB decisions, accumulation of 2^osr
// conversions, and a left-aligned result behind a valid/ready handshake.
module sar_avg_osr_core #(
    parameter int N_BITS        = 12,
    parameter int N_AVG_LSB     = 4,
    parameter int MAX_AVG_LOG2  = 3,
    parameter int MAX_OSR_LOG2  = 4,
    parameter int SAMPLE_CYCLES = 1,
    localparam int W            = N_BITS + MAX_OSR_LOG2
) (
    input  logic              clk_dig_in,
    input  logic              rst_n,
    input  logic              start_in,
    input  logic              continuous_in,
    input  logic [2:0]        config_avg_in,
    input  logic [2:0]        config_osr_in,
    input  logic              comparator_in,
    output logic              enable_loop_out,
    output logic              sample_out,
    output logic [N_BITS-1:0] dac_code_out,
    output logic              busy_out,
    output logic              conv_finished_out,
    output logic [W-1:0]      result_out,
    output logic              result_valid_out,
    input  logic              result_ready_in,
    output logic              overrun_out
);

    localparam int IW = $clog2(N_BITS);
    localparam int RW = MAX_AVG_LOG2 + 2;   // holds 2*ones for up to 2^MAX_AVG_LOG2 votes
    localparam int CW = MAX_OSR_LOG2 + 1;   // holds 2^MAX_OSR_LOG2
    localparam int SW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONVERT, S_ACCUM} state_t;

    state_t            r_state;
    logic [2:0]        r_avg, r_osr;
    logic [SW-1:0]     r_samp;
    logic [IW-1:0]     r_idx;
    logic [RW-1:0]     r_rep, r_ones;
    logic [N_BITS-1:0] r_dac;
    logic [W-1:0]      r_acc;
    logic [CW-1:0]     r_cnt;
    logic              r_en, r_smp, r_busy;
    logic [W-1:0]      r_res;
    logic              r_valid, r_fin, r_ovr;

    logic [2:0]    w_avg_clamp, w_osr_clamp, w_shamt;
    logic [RW-1:0] w_ones, w_rcnt;
    logic          w_avg_bit, w_decide, w_bit, w_last_conv, w_load;
    logic [W-1:0]  w_sum, w_res;
    logic [CW-1:0] w_cnt_nxt, w_osr_tgt;

    assign w_avg_clamp = (config_avg_in > 3'(MAX_AVG_LOG2)) ? 3'(MAX_AVG_LOG2) : config_avg_in;
    assign w_osr_clamp = (config_osr_in > 3'(MAX_OSR_LOG2)) ? 3'(MAX_OSR_LOG2) : config_osr_in;

    // Repeated bits vote: a strict majority of ones keeps the bit, a tie clears it.
    assign w_rcnt    = RW'(1) << r_avg;
    assign w_ones    = r_ones + RW'(comparator_in);
    assign w_avg_bit = int'(r_idx) < N_AVG_LSB;
    assign w_decide  = !w_avg_bit || (r_rep == w_rcnt - RW'(1));
    assign w_bit     = w_avg_bit ? ((w_ones << 1) > w_rcnt) : comparator_in;

    assign w_sum       = r_acc + W'(r_dac);
    assign w_cnt_nxt   = r_cnt + CW'(1);
    assign w_osr_tgt   = CW'(1) << r_osr;
    assign w_last_conv = w_cnt_nxt >= w_osr_tgt;
    assign w_load      = (r_state == S_ACCUM) && w_last_conv;
    assign w_shamt     = 3'(MAX_OSR_LOG2) - r_osr;
    assign w_res       = w_sum << w_shamt;

    // Sequencer: sample, bit-by-bit approximation, accumulate; outputs registered per state.
    always_ff @(posedge clk_dig_in) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_avg   <= '0;
            r_osr   <= '0;
            r_samp  <= '0;
            r_idx   <= '0;
            r_rep   <= '0;
            r_ones  <= '0;
            r_dac   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_smp   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_avg   <= w_avg_clamp;
                        r_osr   <= w_osr_clamp;
                        r_samp  <= '0;
                        r_state <= S_SAMPLE;
                        r_smp   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (r_samp == SW'(SAMPLE_CYCLES - 1)) begin
                        r_state <= S_CONVERT;
                        r_smp   <= 1'b0;
                        r_en    <= 1'b1;
                        r_idx   <= IW'(N_BITS - 1);
                        r_dac   <= N_BITS'(1) << (N_BITS - 1);
                        r_rep   <= '0;
                        r_ones  <= '0;
                    end else begin
                        r_samp <= r_samp + SW'(1);
                    end
                end
                S_CONVERT: begin
                    if (w_decide) begin
                        // Decision and next trial bit land on the same edge.
                        r_dac[r_idx] <= w_bit;
                        if (r_idx != '0)
                            r_dac[r_idx - IW'(1)] <= 1'b1;
                        r_rep  <= '0;
                        r_ones <= '0;
                        if (r_idx == '0) begin
                            r_state <= S_ACCUM;
                            r_en    <= 1'b0;
                        end else begin
                            r_idx <= r_idx - IW'(1);
                        end
                    end else begin
                        r_rep  <= r_rep + RW'(1);
                        r_ones <= w_ones;
                    end
                end
                S_ACCUM: begin
                    r_samp <= '0;
                    r_dac  <= '0;
                    if (w_last_conv) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                        if (continuous_in || start_in) begin
                            r_state <= S_SAMPLE;
                            r_smp   <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_acc   <= w_sum;
                        r_cnt   <= w_cnt_nxt;
                        r_state <= S_SAMPLE;
                        r_smp   <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Result register and handshake; a load always wins over a same-edge accept.
    always_ff @(posedge clk_dig_in) begin
        if (!rst_n) begin
            r_res   <= '0;
            r_valid <= 1'b0;
            r_fin   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_fin <= w_load;
            if (w_load) begin
                r_res   <= w_res;
                r_valid <= 1'b1;
                if (r_valid && !result_ready_in)
                    r_ovr <= 1'b1;
            end else if (result_ready_in) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign enable_loop_out   = r_en;
    assign sample_out        = r_smp;
    assign dac_code_out      = r_dac;
    assign busy_out          = r_busy;
    assign conv_finished_out = r_fin;
    assign result_out        = r_res;
    assign result_valid_out  = r_valid;
    assign overrun_out       = r_ovr;

endmodule

// File: tb/tb_sar_avg_osr_core.sv
// Directed bench for sar_avg_osr_core: table of single-result sequences plus
// hand-written handshake, continuous-mode and reset sequences.
module tb_sar_avg_osr_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_in = 1'b0;
    logic        continuous_in = 1'b0;
    logic [2:0]  config_avg_in = 3'd0;
    logic [2:0]  config_osr_in = 3'd0;
    logic        comparator_in = 1'b0;
    logic        result_ready_in = 1'b0;
    logic        enable_loop_out, sample_out, busy_out, conv_finished_out;
    logic        result_valid_out, overrun_out;
    logic [11:0] dac_code_out;
    logic [15:0] result_out;

    int n_tests = 0;
    int n_fail  = 0;

    sar_avg_osr_core dut (
        .clk_dig_in(clk), .rst_n(rst_n), .start_in(start_in),
        .continuous_in(continuous_in), .config_avg_in(config_avg_in),
        .config_osr_in(config_osr_in), .comparator_in(comparator_in),
        .enable_loop_out(enable_loop_out), .sample_out(sample_out),
        .dac_code_out(dac_code_out), .busy_out(busy_out),
        .conv_finished_out(conv_finished_out), .result_out(result_out),
        .result_valid_out(result_valid_out), .result_ready_in(result_ready_in),
        .overrun_out(overrun_out)
    );

    always #5 clk = ~clk;

    // Comparator model: ideal comparison against the target of the current
    // conversion, optionally overridden by a scripted pattern on the bit-0 trial.
    logic [11:0] cur_t [4];
    logic        cur_use_pat = 1'b0;
    logic [7:0]  cur_pat = 8'd0;
    int          conv_idx = -1;
    int          pat_idx = 0;

    always @(negedge clk) begin
        if (!busy_out) conv_idx = -1;
        if (sample_out) begin
            conv_idx = conv_idx + 1;
            pat_idx  = 0;
        end
        if (cur_use_pat && enable_loop_out && dac_code_out[0]) begin
            comparator_in = cur_pat[pat_idx[2:0]];
            pat_idx = pat_idx + 1;
        end else begin
            comparator_in = (cur_t[conv_idx & 3] >= dac_code_out);
        end
    end

    typedef struct {
        logic [2:0]  avg;
        logic [2:0]  osr;
        logic [11:0] t0, t1, t2, t3;
        logic        use_pat;
        logic [7:0]  pat;
        logic [15:0] exp_res;
        int          exp_lat;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] a, input logic [2:0] o,
                                input logic [11:0] t0, input logic [11:0] t1,
                                input logic [11:0] t2, input logic [11:0] t3,
                                input logic up, input logic [7:0] p,
                                input logic [15:0] r, input int lat);
        vec_t v;
        v.avg = a; v.osr = o; v.t0 = t0; v.t1 = t1; v.t2 = t2; v.t3 = t3;
        v.use_pat = up; v.pat = p; v.exp_res = r; v.exp_lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_targets(input vec_t v);
        cur_t[0] = v.t0; cur_t[1] = v.t1; cur_t[2] = v.t2; cur_t[3] = v.t3;
        cur_use_pat = v.use_pat;
        cur_pat = v.pat;
    endtask

    // One full result sequence: start, scramble config afterwards, time the
    // result, check it, then consume it.
    task automatic run_vec(input vec_t v, input int id);
        int cyc;
        bit seen;
        set_targets(v);
        @(negedge clk);
        config_avg_in = v.avg;
        config_osr_in = v.osr;
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        config_avg_in = 3'd0;
        config_osr_in = 3'd0;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (result_valid_out) seen = 1'b1;
        end
        chk($sformatf("v%0d latency", id), cyc, v.exp_lat);
        chk($sformatf("v%0d result", id), result_out, v.exp_res);
        chk($sformatf("v%0d finished", id), conv_finished_out, 1);
        chk($sformatf("v%0d busy_end", id), busy_out, 0);
        @(negedge clk);
        result_ready_in = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("v%0d valid_clr", id), result_valid_out, 0);
        chk($sformatf("v%0d fin_pulse", id), conv_finished_out, 0);
        result_ready_in = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_fin(input string nm);
        int cyc;
        cyc = 0;
        while (!conv_finished_out && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk(nm, conv_finished_out, 1);
    endtask

    task automatic wait_idle(input string nm);
        int cyc;
        cyc = 0;
        while (busy_out && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk(nm, busy_out, 0);
    endtask

    vec_t vecs [9];
    vec_t v;

    initial begin
        cur_t[0] = 12'h0; cur_t[1] = 12'h0; cur_t[2] = 12'h0; cur_t[3] = 12'h0;
        //                avg   osr   t0      t1      t2      t3     pat  pattern   result    latency
        vecs[0] = mk(3'd0, 3'd0, 12'h326, 12'h326, 12'h326, 12'h326, 0, 8'h00, 16'h3260, 14);
        vecs[1] = mk(3'd2, 3'd2, 12'd806, 12'd2048, 12'd4,  12'd0,   0, 8'h00, 16'h2CA8, 104);
        vecs[2] = mk(3'd1, 3'd0, 12'h326, 12'h326, 12'h326, 12'h326, 1, 8'h01, 16'h3260, 18);
        vecs[3] = mk(3'd1, 3'd0, 12'h326, 12'h326, 12'h326, 12'h326, 1, 8'h03, 16'h3270, 18);
        vecs[4] = mk(3'd2, 3'd0, 12'h326, 12'h326, 12'h326, 12'h326, 1, 8'h03, 16'h3260, 26);
        vecs[5] = mk(3'd2, 3'd0, 12'h326, 12'h326, 12'h326, 12'h326, 1, 8'h0D, 16'h3270, 26);
        vecs[6] = mk(3'd7, 3'd7, 12'h001, 12'h001, 12'h001, 12'h001, 0, 8'h00, 16'h0010, 672);
        vecs[7] = mk(3'd0, 3'd1, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 0, 8'h00, 16'hFFF0, 28);
        vecs[8] = mk(3'd3, 3'd0, 12'h326, 12'h326, 12'h326, 12'h326, 1, 8'h0F, 16'h3260, 42);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {enable_loop_out, sample_out, dac_code_out, busy_out, conv_finished_out,
             result_out, result_valid_out, overrun_out}, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Continuous, ready low: second result overwrites and flags overrun
        do_reset();
        v = vecs[0];
        set_targets(v);
        @(negedge clk);
        continuous_in = 1'b1;
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        wait_fin("ovr first_fin");
        chk("ovr none_yet", overrun_out, 0);
        @(posedge clk); #1;
        wait_fin("ovr second_fin");
        chk("ovr set", overrun_out, 1);
        chk("ovr valid", result_valid_out, 1);
        chk("ovr result", result_out, 16'h3260);
        continuous_in = 1'b0;
        wait_idle("ovr idle");
        @(negedge clk);
        result_ready_in = 1'b1;
        @(posedge clk); #1;
        result_ready_in = 1'b0;
        chk("ovr valid_clr", result_valid_out, 0);
        chk("ovr sticky", overrun_out, 1);
        do_reset();
        chk("ovr reset_clr", overrun_out, 0);

        // Continuous, ready asserted exactly on the second load edge
        set_targets(v);
        @(negedge clk);
        continuous_in = 1'b1;
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        wait_fin("cont first_fin");
        repeat (13) @(posedge clk);
        #1;
        chk("cont no_early_fin", conv_finished_out, 0);
        result_ready_in = 1'b1;
        @(posedge clk); #1;
        chk("cont back_to_back", conv_finished_out, 1);
        chk("cont valid", result_valid_out, 1);
        chk("cont no_overrun", overrun_out, 0);
        continuous_in = 1'b0;
        wait_idle("cont idle");
        result_ready_in = 1'b0;
        chk("cont overrun_end", overrun_out, 0);

        // Reset mid-CONVERT with a partial accumulation pending
        do_reset();
        set_targets(mk(3'd0, 3'd2, 12'h326, 12'h326, 12'h326, 12'h326, 0, 8'h00, 16'h0, 0));
        @(negedge clk);
        config_osr_in = 3'd2;
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rst mid_convert", enable_loop_out, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst outputs_zero",
            {enable_loop_out, sample_out, dac_code_out, busy_out, conv_finished_out,
             result_out, result_valid_out, overrun_out}, 0);
        rst_n = 1'b1;
        run_vec(mk(3'd0, 3'd2, 12'd1, 12'd1, 12'd1, 12'd1, 0, 8'h00, 16'h0010, 56), 99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_avg_osr_core.md
# sar_avg_osr_core

Parametrised successor to the SAR ADC digital core. It runs N_BITS-wide successive approximation with configurable majority-vote repetition on the lowest bits. It accumulates 2^osr conversions and presents a left-aligned result through a valid/ready handshake with overrun flagging. It sits between the comparator latch and clock-loop generator on one side, and the cap-matrix decoder and system bus on the other.

## Interface
- N_BITS, 12, SAR resolution (≥4)
- N_AVG_LSB, 4, number of LSB decisions subject to repetition (1..N_BITS)
- MAX_AVG_LOG2, 3, maximum log2 repetitions per averaged bit
- MAX_OSR_LOG2, 4, maximum log2 conversions accumulated; output width W = N_BITS+MAX_OSR_LOG2
- SAMPLE_CYCLES, 1, cycles spent in SAMPLE (≥1)

- clk_dig_in  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- start_in  in  1  level; in IDLE, starts a result sequence
- continuous_in  in  1  after a result, restart immediately without start_in
- config_avg_in  in  3  log2 repetitions per averaged bit, clamped to MAX_AVG_LOG2
- config_osr_in  in  3  log2 conversions per result, clamped to MAX_OSR_LOG2
- comparator_in  in  1  1 = input above trial code, keep bit
- enable_loop_out  out  1  high in CONVERT only
- sample_out  out  1  high in SAMPLE only
- dac_code_out  out  N_BITS  current trial code to the matrix decoder
- busy_out  out  1  FSM not IDLE
- conv_finished_out  out  1  one-cycle pulse when a result is loaded
- result_out  out  W  accumulated result, left-aligned
- result_valid_out  out  1  result available
- result_ready_in  in  1  consumer accepts the result
- overrun_out  out  1  sticky; an unread result was overwritten

## Operation
- Reset value of every output is 0. Reset also clears the accumulator, counters and the FSM (to IDLE).
- FSM states: IDLE, SAMPLE, CONVERT, ACCUM.
- IDLE -> SAMPLE when start_in=1. On this transition, the clamped config_avg_in/config_osr_in are latched as avg/osr. Config changes at any other time are ignored until the next sequence.
- SAMPLE: lasts SAMPLE_CYCLES. dac_code_out=0. Then enters CONVERT with bit index i=N_BITS-1.
- CONVERT: dac_code_out = decided bits | (1<<i), with lower bits 0. comparator_in is sampled at every edge.
  - For i ≥ N_AVG_LSB: one edge per bit; bit i = comparator_in.
  - For i < N_AVG_LSB: R=2^avg edges per bit, counting ones. Bit i = 1 iff 2·ones > R (tie clears). When avg=0 this is a plain single decision.
  - After bit 0 is decided, go to ACCUM.
- ACCUM: acc += code (W-bit, cannot overflow); conversion counter increments.
  - If the count is < 2^osr, go to SAMPLE.
  - Otherwise: load result_out = acc << (MAX_OSR_LOG2-osr), set result_valid_out=1, pulse conv_finished_out, clear acc and counter. Then go to SAMPLE if continuous_in or start_in, else IDLE.
- Handshake: result_valid_out stays high and result_out stays stable until an edge with result_ready_in=1.
  - New result while valid=1 and ready=0: overwrite, keep valid=1, set overrun_out.
  - New result on the same edge as ready=1: load, valid=1, no overrun.
- Reset mid-operation discards the partial accumulation. The first result after reset contains no residue.

## Timing
- T_conv = SAMPLE_CYCLES + (N_BITS-N_AVG_LSB) + N_AVG_LSB·2^avg + 1 cycles.
- start_in sampled high at edge E0 → result_valid_out rises at edge E0 + 2^osr·T_conv.
- Continuous mode has no dead cycles between conversions or results.
- dac_code_out updates on the same edge that registers the previous decision.

## Test plan
- avg=0, osr=0, comparator drives code 0x326 (806) → T_conv=14; result_out=0x3260 at E0+14; conv_finished_out pulses once.
- avg=2, osr=2, codes 806, 2048, 4, 0 (bit 2 of third code from 4 ones) → sum 0xB2A; result_out=0x2CA8 at E0+104.
- avg=1 on bit 0: comparator 1,0 → bit cleared (tie); 1,1 → bit set. avg=2, ones=2 of 4 → cleared; 3 of 4 → set.
- continuous_in=1, ready=0 → second result overwrites, overrun_out=1 until reset. Repeat with ready=1 on the load edge → overrun_out stays 0.
- rst_n=0 for one edge mid-CONVERT → all outputs 0 next edge. A new osr=2 sequence with codes 1,1,1,1 → result_out=0x0010, with no residue.
- config_avg_in=7, config_osr_in=7 → behave as 3 and 4: T_conv=1+8+32+1=42, 16 conversions. Changing config mid-sequence has no effect.
